bonus_ship_patrol: RTL and testbench



---
 rtl/bonus_ship_patrol_if.sv | 35 +++
 rtl/bonus_ship_patrol.sv | 216 +++++++++++++++++++++
 tb/tb_bonus_ship_patrol.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bonus_ship_patrol_if.sv
// Bonus ship patrol bus: frame/tick strobes, game status and random source
// into the trajectory controller; ship position, status and hit pulse out.
// The master side (game logic / testbench) drives the inputs, the slave side
// (bonus_ship_patrol) drives the ship outputs.
interface bonus_ship_patrol_if #(
    parameter int NUM_PASSES = 2
) ();
    localparam int PC_W = $clog2(NUM_PASSES + 1);

    logic                    startOfFrame;
    logic                    oneSecTick;
    logic                    playGame;
    logic                    bonusFireCollision;
    logic signed [10:0]      alienMatrixYPosition;
    logic        [9:0]       randX;

    logic signed [10:0]      topLeftX;
    logic signed [10:0]      topLeftY;
    logic                    alive;
    logic                    direction;
    logic                    hitPulse;
    logic        [PC_W-1:0]  passCount;

    modport master (
        output startOfFrame, oneSecTick, playGame, bonusFireCollision,
               alienMatrixYPosition, randX,
        input  topLeftX, topLeftY, alive, direction, hitPulse, passCount
    );

    modport slave (
        input  startOfFrame, oneSecTick, playGame, bonusFireCollision,
               alienMatrixYPosition, randX,
        output topLeftX, topLeftY, alive, direction, hitPulse, passCount
    );
endinterface

// File: rtl/bonus_ship_patrol.sv
// Bonus (mystery) ship trajectory controller.
// The ship spawns from a random screen edge, sweeps between two random turn
// points with a dwell at each stop, then leaves in its entry direction.
// Position is kept in signed fixed point with FRAC_BITS fraction bits.
// Optional build macro: BONUS_SHIP_DESCEND_EN -- each turnaround drops the
// ship by DROP_PX pixels (saturating at MAX_Y); default build keeps Y fixed.
module bonus_ship_patrol #(
    parameter int FRAC_BITS     = 6,
    parameter int SPEED         = 40,
    parameter int SCREEN_W      = 640,
    parameter int SHIP_W        = 32,
    parameter int SHIP_Y        = 64,
    parameter int NUM_PASSES    = 2,
    parameter int DWELL_SECONDS = 3,
    parameter int SPAWN_Y_MIN   = 100,
    parameter int RAND_MIN      = 450,
    parameter int DROP_PX       = 16,
    parameter int MAX_Y         = 160
) (
    input  logic                  clk,
    input  logic                  reset,
    bonus_ship_patrol_if.slave    bus
);
    localparam int PW   = 11 + FRAC_BITS;
    localparam int PC_W = $clog2(NUM_PASSES + 1);
    localparam int DC_W = $clog2(DWELL_SECONDS + 1);
    localparam int ONE  = 2 ** FRAC_BITS;

    // Fixed-point constants: left off-screen start, right off-screen start,
    // home row and per-frame step.
    localparam logic signed [PW-1:0] X_OFF_L = PW'(-SHIP_W * ONE);
    localparam logic signed [PW-1:0] X_OFF_R = PW'(SCREEN_W * ONE);
    localparam logic signed [PW-1:0] Y_HOME  = PW'(SHIP_Y * ONE);
    localparam logic signed [PW-1:0] STEP    = PW'(SPEED);

    // Reject configurations that cannot produce a sensible flight.
    generate
        if (NUM_PASSES < 1 || DWELL_SECONDS < 1 || DROP_PX < 0 || MAX_Y < SHIP_Y) begin : g_bad_cfg
            $error("bonus_ship_patrol: invalid parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAVEL,
        S_DWELL,
        S_EXIT
    } state_t;

    state_t                 state_reg;
    logic signed [PW-1:0]   x_reg;
    logic signed [PW-1:0]   y_reg;
    logic signed [PW-1:0]   right_lim_reg;
    logic signed [PW-1:0]   left_lim_reg;
    logic                   dir_reg;
    logic                   entry_dir_reg;
    logic                   alive_reg;
    logic                   hit_reg;
    logic [PC_W-1:0]        pass_cnt_reg;
    logic [DC_W-1:0]        dwell_cnt_reg;
    logic [9:0]             last_rand_reg;
    logic                   tick_prev_reg;

    logic signed [PW-1:0]   x_next;
    logic signed [PW-1:0]   rand_fx;
    logic signed [PW-1:0]   mirror_fx;
    logic [PC_W-1:0]        pass_cnt_next;
    logic                   arrived;
    logic                   off_screen;
    logic                   spawn_ok;
    logic                   tick_rise;

    // Candidate position after this frame's step, and the tests applied to
    // it so an arrival or exit lands on the same edge that applies the step.
    always_comb begin
        x_next     = dir_reg ? (x_reg - STEP) : (x_reg + STEP);
        arrived    = dir_reg ? (x_next <= left_lim_reg) : (x_next >= right_lim_reg);
        off_screen = dir_reg ? (x_next <= X_OFF_L) : (x_next >= X_OFF_R);
    end

    // Turn points derived from the random value: right stop at randX,
    // left stop mirrored about the screen width (may go negative for large randX).
    always_comb begin
        rand_fx   = signed'(PW'(bus.randX)) <<< FRAC_BITS;
        mirror_fx = X_OFF_R - rand_fx;
    end

    // Spawn qualification: game running, aliens low enough, random value
    // large enough and different from the one that launched the last flight.
    always_comb begin
        spawn_ok = bus.playGame
                && (bus.alienMatrixYPosition > 11'(SPAWN_Y_MIN))
                && (bus.randX > 10'(RAND_MIN))
                && (bus.randX != last_rand_reg);
    end

    // The one-second strobe may stay high for several cycles; count its edges.
    always_comb begin
        tick_rise     = bus.oneSecTick && !tick_prev_reg;
        pass_cnt_next = pass_cnt_reg + PC_W'(1);
    end

`ifdef BONUS_SHIP_DESCEND_EN
    localparam logic signed [PW-1:0] DROP_FX = PW'(DROP_PX * ONE);
    localparam logic signed [PW-1:0] MAX_FX  = PW'(MAX_Y * ONE);
    logic signed [PW-1:0] y_drop;

    // Descent applied at each turnaround, clipped at the ceiling row.
    always_comb begin
        y_drop = ((y_reg + DROP_FX) > MAX_FX) ? MAX_FX : (y_reg + DROP_FX);
    end
`endif

    // Flight state machine with registered ship outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            x_reg         <= X_OFF_L;
            y_reg         <= Y_HOME;
            right_lim_reg <= '0;
            left_lim_reg  <= '0;
            dir_reg       <= 1'b0;
            entry_dir_reg <= 1'b0;
            alive_reg     <= 1'b0;
            hit_reg       <= 1'b0;
            pass_cnt_reg  <= '0;
            dwell_cnt_reg <= '0;
            last_rand_reg <= '0;
            tick_prev_reg <= 1'b0;
        end else begin
            tick_prev_reg <= bus.oneSecTick;
            hit_reg       <= 1'b0;

            if (!bus.playGame) begin
                // Game stopped: abandon any flight silently.
                state_reg <= S_IDLE;
                alive_reg <= 1'b0;
            end else if (state_reg != S_IDLE && bus.bonusFireCollision) begin
                // Shot down: wins over an exit on the same cycle.
                state_reg <= S_IDLE;
                alive_reg <= 1'b0;
                hit_reg   <= 1'b1;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (spawn_ok) begin
                            state_reg     <= S_TRAVEL;
                            alive_reg     <= 1'b1;
                            last_rand_reg <= bus.randX;
                            entry_dir_reg <= bus.randX[0];
                            dir_reg       <= bus.randX[0];
                            pass_cnt_reg  <= '0;
                            right_lim_reg <= rand_fx;
                            left_lim_reg  <= mirror_fx;
                            x_reg         <= bus.randX[0] ? X_OFF_R : X_OFF_L;
                            y_reg         <= Y_HOME;
                        end
                    end

                    S_TRAVEL: begin
                        if (bus.startOfFrame) begin
                            // The step is kept even on arrival; no clamp to the limit.
                            x_reg <= x_next;
                            if (arrived) begin
                                state_reg     <= S_DWELL;
                                dwell_cnt_reg <= DC_W'(DWELL_SECONDS);
                            end
                        end
                    end

                    S_DWELL: begin
                        if (dwell_cnt_reg == '0) begin
                            pass_cnt_reg <= pass_cnt_next;
                            if (int'(pass_cnt_next) < NUM_PASSES) begin
                                dir_reg   <= ~dir_reg;
                                state_reg <= S_TRAVEL;
`ifdef BONUS_SHIP_DESCEND_EN
                                y_reg     <= y_drop;
`endif
                            end else begin
                                dir_reg   <= entry_dir_reg;
                                state_reg <= S_EXIT;
                            end
                        end else if (tick_rise) begin
                            dwell_cnt_reg <= dwell_cnt_reg - DC_W'(1);
                        end
                    end

                    S_EXIT: begin
                        if (bus.startOfFrame) begin
                            x_reg <= x_next;
                            if (off_screen) begin
                                state_reg <= S_IDLE;
                                alive_reg <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        state_reg <= S_IDLE;
                        alive_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Integer-pixel view of the fixed-point position (arithmetic shift floors).
    assign bus.topLeftX  = 11'(x_reg >>> FRAC_BITS);
    assign bus.topLeftY  = 11'(y_reg >>> FRAC_BITS);
    assign bus.alive     = alive_reg;
    assign bus.direction = dir_reg;
    assign bus.hitPulse  = hit_reg;
    assign bus.passCount = pass_cnt_reg;

endmodule

// File: tb/tb_bonus_ship_patrol.sv
// Bench for bonus_ship_patrol (default build, NUM_PASSES=2).
// Directed flights; each expected status change (alive/direction/passCount/
// hitPulse) is queued by the stimulus and matched by an independent monitor,
// with direct position checks at the hand-computed frame counts.
module tb_bonus_ship_patrol;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bonus_ship_patrol_if #(.NUM_PASSES(2)) bus ();

    bonus_ship_patrol #(.NUM_PASSES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int alive;
        int dir;
        int pc;
        int hit;
        int x;
        int y;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    bit  mon_en = 1'b0;

    task automatic push_ev(input int alive, input int dir, input int pc, input int hit, input int x);
        ev_t e;
        e.alive = alive; e.dir = dir; e.pc = pc; e.hit = hit; e.x = x; e.y = 64;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 bus.startOfFrame = 1'b1;
            @(posedge clk); #1 bus.startOfFrame = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 bus.oneSecTick = 1'b1;
            repeat (5) @(posedge clk);
            #1 bus.oneSecTick = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    // Monitor: any change of the status tuple is one transaction.
    initial begin : monitor
        int p_alive, p_dir, p_pc, p_hit;
        int c_alive, c_dir, c_pc, c_hit, c_x, c_y;
        ev_t e;
        p_alive = 0; p_dir = 0; p_pc = 0; p_hit = 0;
        forever begin
            @(negedge clk);
            c_alive = int'(bus.alive);
            c_dir   = int'(bus.direction);
            c_pc    = int'(bus.passCount);
            c_hit   = int'(bus.hitPulse);
            c_x     = int'(bus.topLeftX);
            c_y     = int'(bus.topLeftY);
            if (mon_en && (c_alive != p_alive || c_dir != p_dir || c_pc != p_pc || c_hit != p_hit)) begin
                total++;
                $display("event alive=%0d dir=%0d pass=%0d hit=%0d x=%0d y=%0d",
                         c_alive, c_dir, c_pc, c_hit, c_x, c_y);
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got alive=%0d dir=%0d pass=%0d hit=%0d x=%0d, expected none",
                             c_alive, c_dir, c_pc, c_hit, c_x);
                end else begin
                    e = exp_q.pop_front();
                    if (c_alive != e.alive || c_dir != e.dir || c_pc != e.pc ||
                        c_hit != e.hit || c_x != e.x || c_y != e.y) begin
                        bad++;
                        $display("FAIL event: got alive=%0d dir=%0d pass=%0d hit=%0d x=%0d y=%0d, expected alive=%0d dir=%0d pass=%0d hit=%0d x=%0d y=%0d",
                                 c_alive, c_dir, c_pc, c_hit, c_x, c_y,
                                 e.alive, e.dir, e.pc, e.hit, e.x, e.y);
                    end
                end
            end
            p_alive = c_alive; p_dir = c_dir; p_pc = c_pc; p_hit = c_hit;
        end
    end

    initial begin : stimulus
        reset                    = 1'b1;
        bus.startOfFrame         = 1'b0;
        bus.oneSecTick           = 1'b0;
        bus.playGame             = 1'b0;
        bus.bonusFireCollision   = 1'b0;
        bus.alienMatrixYPosition = 11'sd120;
        bus.randX                = 10'd0;
        cyc(3);

        // Reset state
        chk("rst_alive", int'(bus.alive), 0);
        chk("rst_hit",   int'(bus.hitPulse), 0);
        chk("rst_dir",   int'(bus.direction), 0);
        chk("rst_pass",  int'(bus.passCount), 0);
        chk("rst_x",     int'(bus.topLeftX), -32);
        chk("rst_y",     int'(bus.topLeftY), 64);
        reset  = 1'b0;
        mon_en = 1'b1;
        cyc(2);

        // Flight 1: randX=500, enters from the left
        push_ev(1, 0, 0, 0, -32);
        bus.playGame = 1'b1;
        bus.randX    = 10'd500;
        cyc(2);
        chk("spawn_r_x", int'(bus.topLeftX), -32);
        frames(851); chk("r1_pre_arrive_x", int'(bus.topLeftX), 499);
        frames(1);   chk("r1_arrive_x",     int'(bus.topLeftX), 500);
        frames(2);   chk("r1_dwell_frozen", int'(bus.topLeftX), 500);
        chk("r1_dwell_alive", int'(bus.alive), 1);
        push_ev(1, 1, 1, 0, 500);
        ticks(2);    chk("r1_dwell_2ticks_pass", int'(bus.passCount), 0);
        ticks(1);    chk("r1_dwell_3ticks_pass", int'(bus.passCount), 1);
        frames(576); chk("l1_pre_arrive_x", int'(bus.topLeftX), 140);
        frames(1);   chk("l1_arrive_x",     int'(bus.topLeftX), 139);
        frames(2);   chk("l1_dwell_frozen", int'(bus.topLeftX), 139);
        push_ev(1, 0, 2, 0, 139);
        ticks(3);
        push_ev(0, 0, 2, 0, 640);
        frames(800); chk("exit_r_pre_alive", int'(bus.alive), 1);
        chk("exit_r_pre_x", int'(bus.topLeftX), 639);
        frames(1);   chk("exit_r_alive", int'(bus.alive), 0);
        chk("exit_r_pass", int'(bus.passCount), 2);
        cyc(10);     chk("same_rand_blocked", int'(bus.alive), 0);

        // Flight 2: randX=501, enters from the right
        push_ev(1, 1, 0, 0, 640);
        bus.randX = 10'd501;
        cyc(2);
        chk("spawn_l_dir", int'(bus.direction), 1);
        chk("spawn_l_x",   int'(bus.topLeftX), 640);
        frames(801); chk("l2_pre_arrive_x", int'(bus.topLeftX), 139);
        frames(1);   chk("l2_arrive_x",     int'(bus.topLeftX), 138);
        frames(2);   chk("l2_dwell_frozen", int'(bus.topLeftX), 138);
        push_ev(1, 0, 1, 0, 138);
        ticks(3);
        frames(579); chk("r2_pre_arrive_x", int'(bus.topLeftX), 500);
        frames(1);   chk("r2_arrive_x",     int'(bus.topLeftX), 501);
        push_ev(1, 1, 2, 0, 501);
        ticks(3);
        push_ev(0, 1, 2, 0, -33);
        frames(853); chk("exit_l_pre_x", int'(bus.topLeftX), -32);
        frames(1);   chk("exit_l_alive", int'(bus.alive), 0);

        // Flight 3: shot down while dwelling
        push_ev(1, 0, 0, 0, -32);
        bus.randX = 10'd500;
        cyc(2);
        frames(852); chk("f3_arrive_x", int'(bus.topLeftX), 500);
        push_ev(0, 0, 0, 1, 500);
        push_ev(0, 0, 0, 0, 500);
        @(posedge clk); #1 bus.bonusFireCollision = 1'b1;
        @(posedge clk); #1 bus.bonusFireCollision = 1'b0;
        chk("hit_pulse_high", int'(bus.hitPulse), 1);
        chk("hit_alive_low",  int'(bus.alive), 0);
        cyc(1);      chk("hit_pulse_one_cycle", int'(bus.hitPulse), 0);
        cyc(10);     chk("hit_same_rand_blocked", int'(bus.alive), 0);

        // Flight 4: randX=510, abandoned mid-exit by playGame dropping
        push_ev(1, 0, 0, 0, -32);
        bus.randX = 10'd510;
        cyc(2);      chk("f4_spawn_alive", int'(bus.alive), 1);
        frames(868); chk("f4_arrive_r_x", int'(bus.topLeftX), 510);
        push_ev(1, 1, 1, 0, 510);
        ticks(3);
        frames(609); chk("f4_arrive_l_x", int'(bus.topLeftX), 129);
        push_ev(1, 0, 2, 0, 129);
        ticks(3);
        frames(10);  chk("f4_exit_x", int'(bus.topLeftX), 136);
        push_ev(0, 0, 2, 0, 136);
        bus.playGame = 1'b0;
        cyc(2);
        chk("drop_alive", int'(bus.alive), 0);
        chk("drop_hit",   int'(bus.hitPulse), 0);

        // Spawn gating boundaries
        bus.alienMatrixYPosition = 11'sd90;
        bus.randX                = 10'd520;
        bus.playGame             = 1'b1;
        cyc(10); chk("no_spawn_alien_90", int'(bus.alive), 0);
        bus.alienMatrixYPosition = 11'sd100;
        cyc(10); chk("no_spawn_alien_100", int'(bus.alive), 0);
        bus.alienMatrixYPosition = 11'sd120;
        bus.randX                = 10'd400;
        cyc(10); chk("no_spawn_rand_400", int'(bus.alive), 0);
        bus.randX                = 10'd450;
        cyc(10); chk("no_spawn_rand_450", int'(bus.alive), 0);
        push_ev(1, 1, 0, 0, 640);
        bus.alienMatrixYPosition = 11'sd101;
        bus.randX                = 10'd451;
        cyc(2);
        chk("spawn_edge_alive", int'(bus.alive), 1);
        chk("spawn_edge_dir",   int'(bus.direction), 1);

        // Asynchronous reset during travel
        frames(5); chk("f5_travel_x", int'(bus.topLeftX), 636);
        push_ev(0, 0, 0, 0, -32);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_alive", int'(bus.alive), 0);
        chk("async_rst_x",     int'(bus.topLeftX), -32);
        chk("async_rst_hit",   int'(bus.hitPulse), 0);
        bus.playGame = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(20);

        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event: got none, expected alive=%0d dir=%0d pass=%0d hit=%0d x=%0d",
                     e.alive, e.dir, e.pc, e.hit, e.x);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
